// File: rtl/audio_i2s_port.sv
// I2S bridge to a WM8731-class codec (codec is bus master), fully in the clk_clk domain.
// Receives ADC left/right pairs, and serialises DAC pairs taken over a valid/ready handshake.
module audio_i2s_port #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_ADCLRCK,
    input  logic                  AUD_DACLRCK,
    input  logic                  AUD_ADCDAT,
    output logic                  AUD_DACDAT,
    output logic [DATA_WIDTH-1:0] adc_left,
    output logic [DATA_WIDTH-1:0] adc_right,
    output logic                  adc_valid,
    input  logic [DATA_WIDTH-1:0] dac_left,
    input  logic [DATA_WIDTH-1:0] dac_right,
    input  logic                  dac_valid,
    output logic                  dac_ready,
    output logic                  dac_underrun,
    input  logic                  underrun_clear
);

    localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

    // Synchroniser bit order: {ADCDAT, DACLRCK, ADCLRCK, BCLK}
    logic [3:0]            sync1_q, sync2_q;
    logic                  bclk_prev_q, bclk_prev_d;
    logic                  bclk_rise_q, bclk_rise_d;
    logic                  bclk_fall_q, bclk_fall_d;

    logic                  adc_lrck_prev_q, adc_lrck_prev_d;
    logic                  dac_lrck_prev_q, dac_lrck_prev_d;
    logic                  rx_armed_q, rx_armed_d;
    logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] left_buf_q, left_buf_d;
    logic                  left_ok_q, left_ok_d;
    logic [DATA_WIDTH-1:0] adc_left_q, adc_left_d;
    logic [DATA_WIDTH-1:0] adc_right_q, adc_right_d;
    logic                  adc_valid_q, adc_valid_d;

    logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d;
    logic [DATA_WIDTH-1:0] hold_r_q, hold_r_d;
    logic                  hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0] tx_r_q, tx_r_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
    logic                  dacdat_q, dacdat_d;
    logic                  underrun_q, underrun_d;

    logic                  bclk_s, adclrck_s, daclrck_s, adcdat_s;
    logic [DATA_WIDTH-1:0] rx_word;
    logic                  frame_load, underrun_set, accept;

    assign bclk_s    = sync2_q[0];
    assign adclrck_s = sync2_q[1];
    assign daclrck_s = sync2_q[2];
    assign adcdat_s  = sync2_q[3];
    assign rx_word   = {rx_shift_q[DATA_WIDTH-2:0], adcdat_s};
    assign accept    = dac_valid && !hold_full_q;

    always_comb begin
        bclk_prev_d     = bclk_s;
        bclk_rise_d     = bclk_s && !bclk_prev_q;
        bclk_fall_d     = !bclk_s && bclk_prev_q;
        adc_lrck_prev_d = adc_lrck_prev_q;
        dac_lrck_prev_d = dac_lrck_prev_q;
        rx_armed_d      = rx_armed_q;
        rx_cnt_d        = rx_cnt_q;
        rx_shift_d      = rx_shift_q;
        left_buf_d      = left_buf_q;
        left_ok_d       = left_ok_q;
        adc_left_d      = adc_left_q;
        adc_right_d     = adc_right_q;
        adc_valid_d     = 1'b0;
        hold_l_d        = hold_l_q;
        hold_r_d        = hold_r_q;
        hold_full_d     = hold_full_q;
        tx_r_d          = tx_r_q;
        tx_shift_d      = tx_shift_q;
        tx_cnt_d        = tx_cnt_q;
        dacdat_d        = dacdat_q;
        frame_load      = 1'b0;
        underrun_set    = 1'b0;

        if (bclk_rise_q) begin
            adc_lrck_prev_d = adclrck_s;
            dac_lrck_prev_d = daclrck_s;

            // No bits are counted until the first LRCK edge after reset, so a word
            // cut by reset release can never be mistaken for a complete one.
            if (adclrck_s != adc_lrck_prev_q) begin
                rx_cnt_d   = '0;
                rx_armed_d = 1'b1;
            end else if (rx_armed_q && (rx_cnt_q < CNT_FULL)) begin
                rx_shift_d = rx_word;
                rx_cnt_d   = rx_cnt_q + 1'b1;
                if (rx_cnt_q == CNT_LAST) begin
                    if (!adclrck_s) begin
                        left_buf_d = rx_word;
                        left_ok_d  = 1'b1;
                    end else if (left_ok_q) begin
                        adc_left_d  = left_buf_q;
                        adc_right_d = rx_word;
                        adc_valid_d = 1'b1;
                        left_ok_d   = 1'b0;
                    end
                end
            end

            // tx_shift holds the word being sent; the left word goes straight from hold.
            if (daclrck_s != dac_lrck_prev_q) begin
                tx_cnt_d = '0;
                if (!daclrck_s) begin
                    frame_load = 1'b1;
                    if (hold_full_q) begin
                        tx_shift_d = hold_l_q;
                        tx_r_d     = hold_r_q;
                    end else begin
                        tx_shift_d   = '0;
                        tx_r_d       = '0;
                        underrun_set = 1'b1;
                    end
                end else begin
                    tx_shift_d = tx_r_q;
                end
            end
        end

        if (bclk_fall_q) begin
            if (tx_cnt_q < CNT_FULL) begin
                dacdat_d   = tx_shift_q[DATA_WIDTH-1];
                tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                tx_cnt_d   = tx_cnt_q + 1'b1;
            end else begin
                dacdat_d = 1'b0;
            end
        end

        if (accept) begin
            hold_l_d    = dac_left;
            hold_r_d    = dac_right;
            hold_full_d = 1'b1;
        end else if (frame_load && hold_full_q) begin
            hold_full_d = 1'b0;
        end

        if (underrun_set) begin
            underrun_d = 1'b1;
        end else if (underrun_clear) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sync1_q         <= '0;
            sync2_q         <= '0;
            bclk_prev_q     <= 1'b0;
            bclk_rise_q     <= 1'b0;
            bclk_fall_q     <= 1'b0;
            adc_lrck_prev_q <= 1'b0;
            dac_lrck_prev_q <= 1'b0;
            rx_armed_q      <= 1'b0;
            rx_cnt_q        <= '0;
            rx_shift_q      <= '0;
            left_buf_q      <= '0;
            left_ok_q       <= 1'b0;
            adc_left_q      <= '0;
            adc_right_q     <= '0;
            adc_valid_q     <= 1'b0;
            hold_l_q        <= '0;
            hold_r_q        <= '0;
            hold_full_q     <= 1'b0;
            tx_r_q          <= '0;
            tx_shift_q      <= '0;
            tx_cnt_q        <= '0;
            dacdat_q        <= 1'b0;
            underrun_q      <= 1'b0;
        end else begin
            sync1_q         <= {AUD_ADCDAT, AUD_DACLRCK, AUD_ADCLRCK, AUD_BCLK};
            sync2_q         <= sync1_q;
            bclk_prev_q     <= bclk_prev_d;
            bclk_rise_q     <= bclk_rise_d;
            bclk_fall_q     <= bclk_fall_d;
            adc_lrck_prev_q <= adc_lrck_prev_d;
            dac_lrck_prev_q <= dac_lrck_prev_d;
            rx_armed_q      <= rx_armed_d;
            rx_cnt_q        <= rx_cnt_d;
            rx_shift_q      <= rx_shift_d;
            left_buf_q      <= left_buf_d;
            left_ok_q       <= left_ok_d;
            adc_left_q      <= adc_left_d;
            adc_right_q     <= adc_right_d;
            adc_valid_q     <= adc_valid_d;
            hold_l_q        <= hold_l_d;
            hold_r_q        <= hold_r_d;
            hold_full_q     <= hold_full_d;
            tx_r_q          <= tx_r_d;
            tx_shift_q      <= tx_shift_d;
            tx_cnt_q        <= tx_cnt_d;
            dacdat_q        <= dacdat_d;
            underrun_q      <= underrun_d;
        end
    end

    assign AUD_DACDAT   = dacdat_q;
    assign adc_left     = adc_left_q;
    assign adc_right    = adc_right_q;
    assign adc_valid    = adc_valid_q;
    assign dac_ready    = !hold_full_q;
    assign dac_underrun = underrun_q;

endmodule

// File: tb/tb_audio_i2s_port.sv
// Directed bench for audio_i2s_port: a codec model with BCLK = clk/16, 32-bit slots,
// 16-bit words; ADC frames are driven and DACDAT is decoded at each BCLK rise.
module tb_audio_i2s_port;

    logic        clk_clk = 1'b0;
    logic        reset_reset = 1'b1;
    logic        AUD_BCLK = 1'b0;
    logic        AUD_ADCLRCK = 1'b0;
    logic        AUD_DACLRCK = 1'b0;
    logic        AUD_ADCDAT = 1'b0;
    logic        AUD_DACDAT;
    logic [15:0] adc_left, adc_right;
    logic        adc_valid;
    logic [15:0] dac_left = '0;
    logic [15:0] dac_right = '0;
    logic        dac_valid = 1'b0;
    logic        dac_ready;
    logic        dac_underrun;
    logic        underrun_clear = 1'b0;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned vcount  = 0;
    logic [15:0] last_l = '0, last_r = '0;
    logic [15:0] dec_word;
    logic        tail_bad;
    logic        drive_on;
    int unsigned accepts;
    int unsigned vsnap;

    audio_i2s_port #(.DATA_WIDTH(16)) dut (
        .clk_clk       (clk_clk),
        .reset_reset   (reset_reset),
        .AUD_BCLK      (AUD_BCLK),
        .AUD_ADCLRCK   (AUD_ADCLRCK),
        .AUD_DACLRCK   (AUD_DACLRCK),
        .AUD_ADCDAT    (AUD_ADCDAT),
        .AUD_DACDAT    (AUD_DACDAT),
        .adc_left      (adc_left),
        .adc_right     (adc_right),
        .adc_valid     (adc_valid),
        .dac_left      (dac_left),
        .dac_right     (dac_right),
        .dac_valid     (dac_valid),
        .dac_ready     (dac_ready),
        .dac_underrun  (dac_underrun),
        .underrun_clear(underrun_clear)
    );

    always #5 clk_clk = ~clk_clk;

    always @(negedge clk_clk) begin
        if (adc_valid === 1'b1) begin
            vcount = vcount + 1;
            last_l = adc_left;
            last_r = adc_right;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One BCLK period of slot bit b: LRCK/data change at the fall, DACDAT sampled at the rise.
    task automatic bit_cycle(input logic ch, input int b, input logic [15:0] aw);
        AUD_BCLK    = 1'b0;
        AUD_ADCLRCK = ch;
        AUD_DACLRCK = ch;
        AUD_ADCDAT  = (b >= 1 && b <= 16) ? aw[16-b] : 1'b0;
        #80;
        if (b >= 1 && b <= 16) dec_word = {dec_word[14:0], AUD_DACDAT};
        else if (b >= 17 && AUD_DACDAT !== 1'b0) tail_bad = 1'b1;
        AUD_BCLK = 1'b1;
        #80;
    endtask

    task automatic half(input logic ch, input logic [15:0] aw, input int b0, input int b1);
        if (b0 == 0) begin
            dec_word = '0;
            tail_bad = 1'b0;
        end
        for (int b = b0; b < b1; b++) bit_cycle(ch, b, aw);
    endtask

    task automatic frame(input logic [15:0] al, input logic [15:0] ar,
                         output logic [15:0] dl, output logic [15:0] dr, output logic tb);
        half(1'b0, al, 0, 32);
        dl = dec_word;
        tb = tail_bad;
        half(1'b1, ar, 0, 32);
        dr = dec_word;
        tb = tb | tail_bad;
    endtask

    task automatic handshake(input logic [15:0] l, input logic [15:0] r);
        @(negedge clk_clk);
        dac_left  = l;
        dac_right = r;
        dac_valid = 1'b1;
        @(negedge clk_clk);
        dac_valid = 1'b0;
    endtask

    task automatic clear_underrun();
        @(negedge clk_clk);
        underrun_clear = 1'b1;
        @(negedge clk_clk);
        underrun_clear = 1'b0;
    endtask

    initial begin
        logic [15:0] dl, dr;
        logic        tb;

        repeat (4) @(negedge clk_clk);
        chk("reset_adc_left", 32'(adc_left), 32'h0);
        chk("reset_adc_right", 32'(adc_right), 32'h0);
        chk("reset_adc_valid", 32'(adc_valid), 32'h0);
        chk("reset_dacdat", 32'(AUD_DACDAT), 32'h0);
        chk("reset_underrun", 32'(dac_underrun), 32'h0);
        chk("reset_dac_ready", 32'(dac_ready), 32'h1);
        reset_reset = 1'b0;

        // Priming frame: the first LRCK edge after reset only aligns the receiver.
        frame(16'h0000, 16'h0000, dl, dr, tb);
        chk("prime_no_valid", vcount, 0);
        chk("prime_no_underrun", 32'(dac_underrun), 32'h0);

        handshake(16'h8001, 16'h7FFE);
        chk("hs_ready_low", 32'(dac_ready), 32'h0);
        frame(16'hA5C3, 16'h1234, dl, dr, tb);
        chk("A_dac_left", 32'(dl), 32'h8001);
        chk("A_dac_right", 32'(dr), 32'h7FFE);
        chk("A_tail_zero", 32'(tb), 32'h0);
        chk("A_valid_count", vcount, 1);
        chk("A_adc_left", 32'(last_l), 32'hA5C3);
        chk("A_adc_right", 32'(last_r), 32'h1234);
        chk("A_underrun", 32'(dac_underrun), 32'h0);
        chk("A_ready_after_load", 32'(dac_ready), 32'h1);

        frame(16'h0F0F, 16'hF0F0, dl, dr, tb);
        chk("B_dac_left_zero", 32'(dl), 32'h0);
        chk("B_dac_right_zero", 32'(dr), 32'h0);
        chk("B_underrun_set", 32'(dac_underrun), 32'h1);
        chk("B_valid_count", vcount, 2);
        chk("B_adc_left", 32'(last_l), 32'h0F0F);
        chk("B_adc_right", 32'(last_r), 32'hF0F0);
        clear_underrun();
        chk("underrun_cleared", 32'(dac_underrun), 32'h0);
        frame(16'h8000, 16'h0001, dl, dr, tb);
        chk("C_underrun_again", 32'(dac_underrun), 32'h1);
        chk("C_dac_left_zero", 32'(dl), 32'h0);
        chk("C_adc_pair", {last_l, last_r}, 32'h8000_0001);
        clear_underrun();

        // Continuous dac_valid with incrementing data.
        accepts   = 0;
        drive_on  = 1'b1;
        dac_left  = 16'h0100;
        dac_right = 16'h0200;
        fork
            begin
                while (drive_on) begin
                    @(negedge clk_clk);
                    dac_valid = drive_on;
                    if (drive_on && dac_ready) begin
                        @(posedge clk_clk);
                        #1;
                        accepts   = accepts + 1;
                        dac_left  = 16'h0100 + 16'(accepts);
                        dac_right = 16'h0200 + 16'(accepts);
                    end
                end
                dac_valid = 1'b0;
            end
            begin
                for (int f = 0; f < 3; f++) begin
                    frame(16'h1000 + 16'(f), 16'h2000 + 16'(f), dl, dr, tb);
                    chk("stream_dac_left", 32'(dl), 32'h0100 + 32'(f));
                    chk("stream_dac_right", 32'(dr), 32'h0200 + 32'(f));
                    chk("stream_ready_low", 32'(dac_ready), 32'h0);
                end
                drive_on = 1'b0;
            end
        join
        dac_valid = 1'b0;
        chk("stream_accepts", accepts, 4);
        chk("stream_underrun", 32'(dac_underrun), 32'h0);

        // Reset in the middle of a right-channel word while transmitting.
        half(1'b0, 16'h1111, 0, 32);
        chk("G_dac_left", 32'(dec_word), 32'h0103);
        handshake(16'h0AAA, 16'h0555);
        chk("G_hs_ready_low", 32'(dac_ready), 32'h0);
        half(1'b1, 16'h2222, 0, 7);
        vsnap       = vcount;
        AUD_BCLK    = 1'b0;
        AUD_ADCLRCK = 1'b1;
        AUD_DACLRCK = 1'b1;
        AUD_ADCDAT  = 1'b0;
        #80;
        chk("G_bit_before_reset", 32'(AUD_DACDAT), 32'h1);
        reset_reset = 1'b1;
        #1;
        chk("G_async_dacdat", 32'(AUD_DACDAT), 32'h0);
        chk("G_async_ready", 32'(dac_ready), 32'h1);
        chk("G_async_adc_left", 32'(adc_left), 32'h0);
        #39;
        reset_reset = 1'b0;
        #40;
        AUD_BCLK = 1'b1;
        #80;
        half(1'b1, 16'h2222, 8, 32);
        chk("G_no_partial_valid", vcount, vsnap);

        handshake(16'h1357, 16'h2468);
        frame(16'h3C5A, 16'h5A3C, dl, dr, tb);
        chk("H_dac_left", 32'(dl), 32'h1357);
        chk("H_dac_right", 32'(dr), 32'h2468);
        chk("H_tail_zero", 32'(tb), 32'h0);
        chk("H_underrun", 32'(dac_underrun), 32'h0);
        chk("H_valid_count", vcount, vsnap + 1);
        chk("H_adc_left", 32'(last_l), 32'h3C5A);
        chk("H_adc_right", 32'(last_r), 32'h5A3C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
